// File: rtl/lpc_postcode_hist_if.sv
// ============================================================================
// lpc_postcode_hist_if : LPC I/O decode and history-consumer signal bundle
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface lpc_postcode_hist_if #(
   parameter int CODE_BYTES = 2,
   parameter int DEPTH      = 16
);
   logic                          lpc_en;
   logic                          device_cs;
   logic [15:0]                   addr;
   logic [7:0]                    din;
   logic                          io_wren;
   logic                          io_rden;
   logic [7:0]                    dout;
   logic                          dout_oe;
   logic [8*CODE_BYTES-1:0]       postcode;
   logic                          code_valid;
   logic                          hist_rd;
   logic                          hist_clr;
   logic [8*CODE_BYTES-1:0]       hist_data;
   logic                          hist_empty;
   logic                          hist_full;
   logic [$clog2(DEPTH):0]        hist_count;
   logic                          hist_ovf;

   modport master (
      output lpc_en, device_cs, addr, din, io_wren, io_rden, hist_rd, hist_clr,
      input  dout, dout_oe, postcode, code_valid, hist_data, hist_empty,
             hist_full, hist_count, hist_ovf
   );

   modport slave (
      input  lpc_en, device_cs, addr, din, io_wren, io_rden, hist_rd, hist_clr,
      output dout, dout_oe, postcode, code_valid, hist_data, hist_empty,
             hist_full, hist_count, hist_ovf
   );
endinterface

`default_nettype wire

// File: rtl/lpc_postcode_hist.sv
// ============================================================================
// lpc_postcode_hist : multi-byte LPC POST-code capture with FWFT history FIFO
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lpc_postcode_hist #(
   parameter int          CODE_BYTES = 2,
   parameter logic [15:0] BASE_ADDR  = 16'h0080,
   parameter int          DEPTH      = 16,
   parameter int          TIMEOUT    = 1024
) (
   input  logic               lclk,
   input  logic               lreset_n,
   lpc_postcode_hist_if.slave bus
);
   localparam int c_CW = 8 * CODE_BYTES;
   localparam int c_LW = (CODE_BYTES > 1) ? $clog2(CODE_BYTES) : 1;
   localparam int c_AW = $clog2(DEPTH);
   localparam int c_TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [15:0]     c_NLANES  = 16'(CODE_BYTES);
   localparam logic [c_LW-1:0] c_TOP     = c_LW'(CODE_BYTES - 1);
   localparam logic [c_TW-1:0] c_TO_LAST = c_TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [c_AW:0]   c_FULL    = (c_AW + 1)'(DEPTH);

   logic [c_CW-1:0] staging_q, staging_d;
   logic [c_CW-1:0] postcode_q;
   logic            pending_q, pending_d;
   logic            code_valid_q;
   logic [c_TW-1:0] to_cnt_q, to_cnt_d;
   logic [c_CW-1:0] mem_q [DEPTH];
   logic [c_AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [c_AW:0]   cnt_q, cnt_d;
   logic            ovf_q, ovf_d;

   logic [15:0]     w_off;
   logic [c_LW-1:0] w_lane;
   logic            w_hit, w_wr, w_rd, w_wr_top, w_wr_low;
   logic            w_to_fire, w_rewrite, w_commit, w_push, w_pop, w_full;
   logic [c_CW-1:0] w_commit_val;

   assign w_off     = bus.addr - BASE_ADDR;
   assign w_lane    = w_off[c_LW-1:0];
   assign w_hit     = bus.device_cs & bus.lpc_en & (w_off < c_NLANES);
   assign w_wr      = w_hit & bus.io_wren;
   assign w_rd      = w_hit & bus.io_rden;
   assign w_wr_top  = w_wr & (w_lane == c_TOP);
   assign w_wr_low  = w_wr & (w_lane != c_TOP);
   assign w_to_fire = (TIMEOUT != 0) & pending_q & ~w_wr & (to_cnt_q == c_TO_LAST);
   // A lane-0 write while pending flushes the older code before overwriting it
   assign w_rewrite = w_wr & (w_lane == '0) & pending_q;
   assign w_commit  = w_wr_top | w_rewrite | w_to_fire;
   assign w_commit_val = w_wr_top ? staging_d : staging_q;

   always_comb begin
      staging_d = staging_q;
      for (int k = 0; k < CODE_BYTES; k++) begin
         if (w_wr && (w_lane == c_LW'(k))) staging_d[8*k +: 8] = bus.din;
      end
   end

   always_comb begin
      pending_d = pending_q;
      if (w_wr_top)       pending_d = 1'b0;
      else if (w_wr_low)  pending_d = 1'b1;
      else if (w_to_fire) pending_d = 1'b0;
      to_cnt_d = to_cnt_q;
      if (bus.hist_clr || w_wr || w_commit) to_cnt_d = '0;
      else if (pending_q)                   to_cnt_d = to_cnt_q + c_TW'(1);
   end

   assign w_full = (cnt_q == c_FULL);
   assign w_push = w_commit & ~bus.hist_clr;
   assign w_pop  = bus.hist_rd & (cnt_q != '0);

   // Full without a simultaneous pop: advance the read pointer to drop the oldest
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (bus.hist_clr) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
         ovf_d = 1'b0;
      end else begin
         if (w_pop) begin
            rd_d  = rd_q + c_AW'(1);
            cnt_d = cnt_q - (c_AW + 1)'(1);
         end
         if (w_push) begin
            wr_d = wr_q + c_AW'(1);
            if (w_full && !w_pop) begin
               rd_d  = rd_q + c_AW'(1);
               ovf_d = 1'b1;
            end else begin
               cnt_d = cnt_d + (c_AW + 1)'(1);
            end
         end
      end
   end

   always_ff @(posedge lclk or negedge lreset_n) begin
      if (!lreset_n) begin
         staging_q    <= '0;
         postcode_q   <= '0;
         pending_q    <= 1'b0;
         code_valid_q <= 1'b0;
         to_cnt_q     <= '0;
         wr_q         <= '0;
         rd_q         <= '0;
         cnt_q        <= '0;
         ovf_q        <= 1'b0;
      end else begin
         staging_q    <= staging_d;
         pending_q    <= pending_d;
         code_valid_q <= w_commit;
         to_cnt_q     <= to_cnt_d;
         wr_q         <= wr_d;
         rd_q         <= rd_d;
         cnt_q        <= cnt_d;
         ovf_q        <= ovf_d;
         if (w_commit) postcode_q <= w_commit_val;
      end
   end

   always_ff @(posedge lclk) begin
      if (w_push) mem_q[wr_q] <= w_commit_val;
   end

   always_comb begin
      bus.dout    = 8'h00;
      bus.dout_oe = 1'b0;
      if (w_rd) begin
         bus.dout_oe = 1'b1;
         for (int k = 0; k < CODE_BYTES; k++) begin
            if (w_lane == c_LW'(k)) bus.dout = postcode_q[8*k +: 8];
         end
      end
   end

   assign bus.postcode   = postcode_q;
   assign bus.code_valid = code_valid_q;
   assign bus.hist_data  = (cnt_q == '0) ? '0 : mem_q[rd_q];
   assign bus.hist_empty = (cnt_q == '0);
   assign bus.hist_full  = w_full;
   assign bus.hist_count = cnt_q;
   assign bus.hist_ovf   = ovf_q;
endmodule

`default_nettype wire

// File: doc/lpc_postcode_hist.md
# lpc_postcode_hist

Parametrised POST-code capture block on the LPC I/O decode path. Captures multi-byte POST codes written to consecutive I/O ports starting at `BASE_ADDR`, presents the latest committed code, supports LPC readback, and keeps a first-word-fall-through history FIFO that a local consumer (debug UART, LED sequencer) drains. With `CODE_BYTES=1` it matches the single-port 8-bit capture behaviour, adding history.

## Interface
- `CODE_BYTES`, 2: code width in bytes, 1..4; lanes occupy `BASE_ADDR` .. `BASE_ADDR+CODE_BYTES-1`.
- `BASE_ADDR`, 16'h0080: I/O address of lane 0.
- `DEPTH`, 16: history entries, power of 2, 2..256.
- `TIMEOUT`, 1024: cycles after a partial write before an automatic commit; 0 disables it.

- `lclk`  in  1  LPC clock.
- `lreset_n`  in  1  reset, asynchronous, active-low.
- `lpc_en`  in  1  transaction-data-valid qualifier.
- `device_cs`  in  1  decoder select for this block's address window.
- `addr`  in  16  I/O address.
- `din`  in  8  write data.
- `io_wren`  in  1  I/O write strobe.
- `io_rden`  in  1  I/O read strobe.
- `dout`  out  8  readback data, 8'h00 when not driving.
- `dout_oe`  out  1  high while `dout` is valid.
- `postcode`  out  8*CODE_BYTES  last committed code.
- `code_valid`  out  1  one-cycle pulse on each commit.
- `hist_rd`  in  1  pop request from the local consumer.
- `hist_clr`  in  1  clears the FIFO and overflow flag.
- `hist_data`  out  8*CODE_BYTES  FIFO head (FWFT); 0 when empty.
- `hist_empty` / `hist_full`  out  1  FIFO status.
- `hist_count`  out  clog2(DEPTH)+1  occupancy.
- `hist_ovf`  out  1  sticky; set when an entry was overwritten.

## Operation
- Lane hit: `device_cs & lpc_en & (addr - BASE_ADDR) < CODE_BYTES`. Lane k = `addr - BASE_ADDR`.
- Write to lane k: `staging[8k+7:8k] <= din`. Bytes not written keep their previous staging value.
- Commit on a write to the top lane (`CODE_BYTES-1`). The commit uses staging with the new top byte merged in. Commit actions:
  - `postcode` gets the merged value;
  - `code_valid` pulses;
  - the value is pushed to the FIFO.
- Pending: set by a write to any lower lane, cleared by commit.
- Timeout: the counter reloads on every lower-lane write. If pending persists for `TIMEOUT` cycles with no lane write, the staging value is committed.
- Re-write while pending: a write to lane 0 while pending first commits the pending staging value, then writes lane 0 into staging. Pending stays set. This preserves back-to-back codes whose top byte was skipped.
- `CODE_BYTES=1`: every write commits immediately; pending never sets.
- Readback: an `io_rden` lane hit drives `dout = postcode` byte k with `dout_oe=1`, combinationally. Otherwise `dout=0`, `dout_oe=0`.
- FIFO policy:
  - push when full: drop the oldest entry and set `hist_ovf`;
  - push + pop when full: normal pop then push, no overflow;
  - pop when empty: ignored.
- `hist_clr`:
  - empties the FIFO and clears `hist_ovf` and the timeout count;
  - has priority over a push in the same cycle, so that push is lost;
  - does not alter `postcode` or staging.
- Reset values: `postcode`, staging, pending, counters and pointers 0; `code_valid` 0; `hist_empty` 1; `hist_full` 0; `hist_count` 0; `hist_ovf` 0.

## Timing
- Commit write sampled at edge N: `postcode`, `code_valid`, `hist_count`, `hist_empty` and `hist_data` (if the FIFO was empty) all update after edge N (1-cycle latency).
- Timeout commit: the last lower-lane write at edge N makes `code_valid` high after edge N+TIMEOUT.
- `hist_rd` sampled at edge N: the next entry appears on `hist_data` after edge N.
- Async reset mid-transaction aborts pending and discards any partial staging value.

## Test plan
- Reset with `CODE_BYTES=2` -> `postcode=0`, `hist_empty=1`, `dout_oe=0`.
- Write 0x80=0x34, then 0x81=0x12 -> `postcode=16'h1234`, one `code_valid` pulse, `hist_count=1`, `hist_data=16'h1234`.
- Write 0x80=0xAA only, idle `TIMEOUT` cycles -> commit of `16'h12AA` exactly `TIMEOUT` cycles after the write.
- Write 0x80=0x01, then 0x80=0x02, then 0x81=0x00 -> FIFO holds `16'h1201`, then `16'h0002`.
- `DEPTH=4`: 5 commits of 1..5 with no pop -> `hist_ovf=1`, `hist_full=1`, pops return 2,3,4,5; a further pop when empty is ignored.
- Read 0x81 after commit of `16'h1234` -> `dout=8'h12`, `dout_oe=1`. Push and pop in the same cycle when full -> `hist_ovf` stays 0 and count stays 4.
